// File: rtl/pc_redirect_unit.sv
// PC owner and branch/jump redirect controller with multi-cycle front-end flush.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | sequential fetch; taken branches in EX are accepted
// PENDING | taken branch captured under stall; waits for stall release
// FLUSH   | squashed front-end instructions draining; branches ignored
module pc_redirect_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC     = 32'h0000_0000,
  parameter int unsigned       FLUSH_CYCLES = 2
`ifdef MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            redirect
`ifdef MISALIGN_TRAP_EN
  , output logic            misalign_trap,
  output logic [XLEN-1:0] trap_addr
`endif
);

  typedef enum logic [1:0] {RUN, PENDING, FLUSH} state_t;

  localparam logic [2:0] CNT_INIT  = 3'(FLUSH_CYCLES - 1);
  localparam bit         ONE_CYCLE = (FLUSH_CYCLES == 1);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            flush_q, flush_d;
  logic            redirect_q, redirect_d;

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] load_pc;
  logic            take;
  logic            do_load;

`ifdef MISALIGN_TRAP_EN
  logic            trap_q, trap_d;
  logic [XLEN-1:0] taddr_q, taddr_d;
  logic            misaligned;
`endif

  always_comb begin
    jalr_sum     = rs1_data + imm;
    target_raw   = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (ex_pc + imm);
    redirect_tgt = (state_q == PENDING) ? pend_q : target_raw;
`ifdef MISALIGN_TRAP_EN
    misaligned   = |redirect_tgt[1:0];
    load_pc      = misaligned ? TRAP_VECTOR : redirect_tgt;
`else
    load_pc      = redirect_tgt & {{(XLEN-2){1'b1}}, 2'b00};
`endif
    // The EX slot right after a one-cycle flush holds a squashed instruction.
    take = branch_valid & branch_taken & ~flush_q;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    redirect_d = 1'b0;
    do_load    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap_d     = 1'b0;
    taddr_d    = taddr_q;
`endif

    case (state_q)
      RUN: begin
        if (!stall) flush_d = 1'b0;
        if (take && !stall) begin
          do_load = 1'b1;
        end else if (take) begin
          pend_d  = target_raw;
          state_d = PENDING;
        end else if (!stall) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      PENDING: begin
        if (!stall) do_load = 1'b1;
      end
      FLUSH: begin
        if (!stall) begin
          pc_d = pc_q + XLEN'(4);
          if (cnt_q == 3'd0) begin
            flush_d = 1'b0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (do_load) begin
      pc_d       = load_pc;
      redirect_d = 1'b1;
      flush_d    = 1'b1;
      cnt_d      = CNT_INIT;
      state_d    = ONE_CYCLE ? RUN : FLUSH;
`ifdef MISALIGN_TRAP_EN
      trap_d     = misaligned;
      if (misaligned) taddr_d = redirect_tgt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      cnt_q      <= 3'd0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
      taddr_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
`ifdef MISALIGN_TRAP_EN
      trap_q     <= trap_d;
      taddr_q    <= taddr_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign redirect = redirect_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
  assign trap_addr     = taddr_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: vector table plus hand-written sequences.
// Trap checks are compiled in when MISALIGN_TRAP_EN is defined.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic        branch_taken = 1'b0;
  logic        is_jalr = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] pc;
  logic        flush;
  logic        redirect;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
  logic [31:0] trap_addr;
  localparam logic [31:0] MIS_PC = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_PC = 32'h0000_0040;
`endif

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_taken (branch_taken),
    .is_jalr      (is_jalr),
    .ex_pc        (ex_pc),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .pc           (pc),
    .flush        (flush),
    .redirect     (redirect)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap),
    .trap_addr    (trap_addr)
`endif
  );

  typedef struct {
    logic        r, s, bv, bt, j;
    logic [31:0] ep, im, rs;
    logic [31:0] e_pc;
    logic        e_fl, e_rd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_redirect = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, s, bv, bt, j, input logic [31:0] ep, im, rs,
                     input logic [31:0] e_pc, input logic e_fl, e_rd);
    vec_t v;
    v.r = r; v.s = s; v.bv = bv; v.bt = bt; v.j = j;
    v.ep = ep; v.im = im; v.rs = rs;
    v.e_pc = e_pc; v.e_fl = e_fl; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, s, bv, bt, j, input logic [31:0] ep, im, rs);
    @(negedge clk);
    rst_n = r; stall = s; branch_valid = bv; branch_taken = bt; is_jalr = j;
    ex_pc = ep; imm = im; rs1_data = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] e_pc, input logic e_fl, e_rd);
    chk({nm, ".pc"}, pc, e_pc);
    chk({nm, ".flush"}, 32'(flush), 32'(e_fl));
    chk({nm, ".redirect"}, 32'(redirect), 32'(e_rd));
  endtask

  // redirect must never stay high across two consecutive cycles
  always @(negedge clk) begin
    if (redirect) chk("redirect_back_to_back", 32'(prev_redirect), 32'd0);
    prev_redirect = redirect;
  end

  initial begin
    //   r  s  bv bt j   ex_pc          imm            rs1            exp_pc         fl rd
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0000, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0000, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0004, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0008, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_000C, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0010, 0, 0);
    add(1, 0, 1, 1, 0, 32'h40,        32'hFFFF_FFF0, 32'h0,         32'h0000_0030, 1, 1);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0034, 1, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0038, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_003C, 0, 0);
    add(1, 0, 1, 0, 0, 32'h40,        32'h100,       32'h0,         32'h0000_0040, 0, 0);
    add(1, 0, 1, 1, 1, 32'h999,       32'h8,         32'hFFFF_FFFD, 32'h0000_0004, 1, 1);
    add(1, 0, 1, 1, 0, 32'h200,       32'h0,         32'h0,         32'h0000_0008, 1, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_000C, 0, 0);
    add(1, 1, 1, 1, 0, 32'h80,        32'h20,        32'h0,         32'h0000_000C, 0, 0);
    add(1, 1, 1, 1, 1, 32'h500,       32'h4,         32'h700,       32'h0000_000C, 0, 0);
    add(1, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_000C, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_00A0, 1, 1);
    add(1, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_00A0, 1, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_00A4, 1, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_00A8, 0, 0);
    add(1, 1, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_00A8, 0, 0);
    add(1, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h8,         32'h0,         32'h0000_0004, 1, 1);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0008, 1, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_000C, 0, 0);
    add(1, 0, 1, 1, 0, 32'h100,       32'h10,        32'h0,         32'h0000_0110, 1, 1);
    add(0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0000, 0, 0);
    add(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0000_0004, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].bv, vecs[i].bt, vecs[i].j,
           vecs[i].ep, vecs[i].im, vecs[i].rs);
      chk_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_rd);
    end

`ifdef MISALIGN_TRAP_EN
    chk("trap_reset", 32'(misalign_trap), 32'd0);
    chk("taddr_reset", trap_addr, 32'h0);
`endif
    // misaligned target 0x42
    step(1, 0, 1, 1, 0, 32'h40, 32'h2, 32'h0);
    chk_out("mis0", MIS_PC, 1, 1);
`ifdef MISALIGN_TRAP_EN
    chk("mis0.trap", 32'(misalign_trap), 32'd1);
    chk("mis0.taddr", trap_addr, 32'h42);
`endif
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk_out("mis1", MIS_PC + 32'h4, 1, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis1.trap", 32'(misalign_trap), 32'd0);
    chk("mis1.taddr", trap_addr, 32'h42);
`endif
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk_out("mis2", MIS_PC + 32'h8, 0, 0);

    // taken branch held in EX for four cycles: only the RUN-state cycles redirect
    step(1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h0);
    chk_out("hold0", 32'h300, 1, 1);
    step(1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h0);
    chk_out("hold1", 32'h304, 1, 0);
    step(1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h0);
    chk_out("hold2", 32'h308, 0, 0);
    step(1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h0);
    chk_out("hold3", 32'h300, 1, 1);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk_out("hold4", 32'h304, 1, 0);
    step(1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk_out("hold5", 32'h308, 0, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and consumes the branch decision produced by the EX-stage branch comparator (branch_taken).
- Computes the branch/jump target, redirects the PC, and drives a multi-cycle flush of the squashed front-end stages.
- Holds a redirect that arrives during a pipeline stall until the stall releases.
- Sits between the EX-stage branch comparator and the IF-stage instruction-memory address port.

Parameters:
XLEN, 32, datapath/address width (matches RISCV.h)
RESET_PC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal 1..7)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  pipeline hold; PC and flush counter freeze while high
branch_valid  input  1  EX stage holds a branch/jump instruction (B-type, JAL, JALR)
branch_taken  input  1  comparator decision for the EX instruction (1 = take)
is_jalr  input  1  EX instruction is JALR (target = rs1 + imm)
ex_pc  input  XLEN  PC of the EX-stage instruction
imm  input  XLEN  sign-extended immediate of the EX instruction
rs1_data  input  XLEN  rs1 operand (JALR base)
pc  output  XLEN  current fetch address
flush  output  1  kill instructions in IF/ID and ID/EX
redirect  output  1  one-cycle pulse: PC was loaded with a target this cycle

Behaviour:
- Reset (rst_n=0 at an edge): pc=RESET_PC, flush=0, redirect=0, state=RUN, flush counter=0, pending target cleared. Reset wins over every other event, including a redirect in flight.
- Target arithmetic, modulo 2^XLEN (carry discarded, wrap 32'hFFFF_FFFC+8 -> 32'h0000_0004):
  - JALR: (rs1_data+imm) with bit0 cleared.
  - Otherwise: ex_pc+imm.
- take = branch_valid & branch_taken, sampled only in RUN.
- States: RUN, PENDING, FLUSH. All outputs are registered.
- RUN:
  - take & !stall: at the next edge pc=target, redirect=1, flush=1, counter=FLUSH_CYCLES-1. Go to FLUSH, or to RUN if FLUSH_CYCLES=1.
  - take & stall: capture target into the pending register, pc holds. Go to PENDING.
  - !take & !stall: pc=pc+4.
  - stall alone: pc holds.
- PENDING:
  - branch inputs ignored.
  - Stays while stall=1.
  - First cycle with stall=0: pc=pending target at the next edge, redirect=1, flush=1. Go to FLUSH (counter as in RUN).
- FLUSH:
  - flush stays 1, redirect=0, branch inputs ignored (squashed instructions).
  - Each non-stalled cycle: counter decrements and pc=pc+4.
  - Counter 0 and !stall: flush=0 at the next edge, return to RUN.
  - stall freezes pc and counter; flush stays 1.
- Redirect latency: taken branch in EX in cycle N (no stall) -> pc=target and flush=1 visible in cycle N+1. flush is high for exactly FLUSH_CYCLES non-stalled cycles.
- redirect is never high for two consecutive cycles.
- Not-taken branch (branch_valid=1, branch_taken=0) is treated identically to a non-branch.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Adds ports TRAP_VECTOR parameter (default 32'h0000_0100), misalign_trap output 1, trap_addr output XLEN.
  - A redirect whose target[1:0]!=0 loads pc=TRAP_VECTOR instead of the target.
  - misalign_trap=1 for one cycle, trap_addr=offending target; flush sequence unchanged.
  - Both new outputs reset to 0.
- When undefined: those ports are absent, and target[1:0] is forced to 2'b00 before loading pc.

Test Plan:
- Reset: rst_n=0 for 2 edges, then 1, stall=0, no branches -> pc=0,4,8,12; flush=0, redirect=0 throughout.
- Taken branch: in cycle N, ex_pc=0x40, imm=0xFFFFFFF0, branch_valid=1, branch_taken=1 -> cycle N+1 pc=0x30, redirect=1, flush=1. Cycle N+2 flush=1, pc=0x34. Cycle N+3 flush=0, pc=0x38.
- JALR with wrap: rs1_data=0xFFFFFFFD, imm=8, is_jalr=1, taken -> pc=0x00000004 next cycle (bit0 cleared, carry discarded).
- Stall during branch: taken branch with stall=1 for 3 cycles -> pc unchanged, state PENDING. Stall drops -> next cycle pc=target, redirect=1, flush held 2 non-stalled cycles.
- Branch during flush: second branch_valid=1, branch_taken=1 presented while flush=1 -> ignored; pc continues +4, no second redirect pulse.
- Reset mid-flush plus MISALIGN_TRAP_EN: rst_n=0 while flush=1 -> pc=RESET_PC, flush=0 at the next edge. With the macro defined, taken target 0x42 -> pc=0x100, misalign_trap=1 for one cycle, trap_addr=0x42.
